dec_share_sched: RTL and testbench
==================================

Name: dec_share_sched

Overview:
- Round-robin scheduler that shares one W-bit decrement datapath among NREQ requesters. The datapath computes out = (in - 1) mod 2^W.
- Each request carries an operand and a pass count. The block applies the decrement once per cycle for count passes, then returns (operand - count) mod 2^W tagged with the requester id.
- Sits between requester agents and the single shared decrement unit. Serialises access; one operation is in flight at a time.

Parameters:
- NREQ, 4, number of requesters.
- W, 2, operand/result width; all arithmetic is mod 2^W.
- IDW, 2, width of resp_id; must satisfy 2^IDW >= NREQ.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  NREQ  bit i: requester i has a request pending.
- req_data  input  NREQ*W  operand of requester i at [i*W +: W].
- req_count  input  NREQ*W  pass count of requester i at [i*W +: W]; 0 is legal.
- req_ready  output  NREQ  one-hot accept; request i is taken when req_valid[i] & req_ready[i].
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts result.
- resp_data  output  W  (operand - count) mod 2^W.
- resp_id  output  IDW  index of the granted requester.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, rr pointer ptr=0, acc=0, cnt=0, id=0.
  - Outputs: req_ready=0, resp_valid=0, resp_data=0, resp_id=0, busy=0.
  - Reset asserted mid-operation abandons the operation; no response is ever issued for it.
- State machine: IDLE, RUN, RESP.
- IDLE:
  - g = first i with req_valid[i], searching ptr, ptr+1, ..., wrapping NREQ-1 -> 0.
  - req_ready is combinational: one-hot at g when any req_valid is high, else 0. It is never asserted outside IDLE.
  - On accept: acc<=req_data[g], cnt<=req_count[g], id<=g, ptr<=(g+1) mod NREQ.
  - Next state is RUN if req_count[g] != 0, else RESP.
- RUN:
  - Each cycle acc<=datapath(acc) = acc-1 mod 2^W and cnt<=cnt-1.
  - Leave for RESP when cnt==1, after that cycle's decrement.
  - Decrement wraps: 0 -> 2^W-1.
- RESP:
  - resp_valid=1; resp_data=acc and resp_id=id, held stable until resp_ready=1.
  - On handshake, go to IDLE. No request is accepted in the same cycle (one bubble).
- Latency, accept edge to resp_valid high: count+1 cycles. count=0 gives 1 cycle.
- Throughput: at most one operation per count+2 cycles with resp_ready held high.
- Requester obligations:
  - Hold req_valid, req_data and req_count stable until accepted.
  - Changing data or count before accept is unspecified.
  - Dropping req_valid before accept is legal and simply withdraws the request.
- Non-granted requesters' valids are ignored while busy.
- resp_data/resp_id values outside RESP are don't-care for checking; the design holds the last values.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> all outputs 0 immediately, state IDLE. Release, then req0 valid -> req_ready=4'b0001 (grant from ptr=0).
- Single op: req0 data=2'b00 count=1, accept at edge T -> resp_valid high after edge T+1 with resp_data=2'b11, resp_id=0; busy high from T until the resp handshake.
- Zero count: req2 data=2'b10 count=0 -> resp_valid one cycle after accept, resp_data=2'b10, resp_id=2.
- Multi-pass wrap: req1 data=2'b01 count=3 -> three RUN cycles, acc sequence 00, 11, 10; resp_data=2'b10, resp_id=1.
- Round robin: all four req_valid held high, count=0, resp_ready=1 -> grant order 0,1,2,3,0,1 with one bubble between ops; no requester starved.
- Backpressure/reset: resp_ready=0 for 5 cycles -> resp_valid, data and id stable and req_ready=0 throughout. Separately, rst pulsed during RUN with count=3 -> resp_valid never rises for that op, next grant starts from ptr=0.

Source files
------------

// File: rtl/dec_share_sched.sv
// Round-robin scheduler sharing one mod-2^W decrement unit among NREQ requesters.
// Latency count+1 cycles after accept; resp held until resp_ready, no accepts while busy.
module dec_share_sched #(
  parameter int NREQ = 4,
  parameter int W    = 2,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  input  logic [NREQ*W-1:0] req_count,
  output logic [NREQ-1:0]   req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [W-1:0]      resp_data,
  output logic [IDW-1:0]    resp_id,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_ptr;
  logic [W-1:0]     r_acc;
  logic [W-1:0]     r_cnt;
  logic [IDW-1:0]   r_id;
  logic             r_resp_valid;
  logic             r_busy;

  logic             w_any;
  logic [IDW-1:0]   w_g;
  logic [IDW-1:0]   w_idx;
  logic [W-1:0]     w_g_data;
  logic [W-1:0]     w_g_cnt;
  logic [W-1:0]     w_dec;
  logic [IDW-1:0]   w_ptr_next;

  // Scan from the highest offset down so the candidate nearest r_ptr wins.
  always_comb begin
    w_any = 1'b0;
    w_g   = '0;
    w_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = IDW'((int'(r_ptr) + k) % NREQ);
      if (req_valid[w_idx]) begin
        w_any = 1'b1;
        w_g   = w_idx;
      end
    end
  end

  assign w_g_data   = req_data[w_g*W +: W];
  assign w_g_cnt    = req_count[w_g*W +: W];
  assign w_dec      = r_acc - W'(1);
  assign w_ptr_next = (w_g == IDW'(NREQ - 1)) ? '0 : w_g + IDW'(1);

  assign req_ready  = (r_state == ST_IDLE && w_any && !rst) ? (NREQ'(1) << w_g) : '0;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_acc;
  assign resp_id    = r_id;
  assign busy       = r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_id         <= '0;
      r_resp_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_acc  <= w_g_data;
            r_cnt  <= w_g_cnt;
            r_id   <= w_g;
            r_ptr  <= w_ptr_next;
            r_busy <= 1'b1;
            if (w_g_cnt != '0) begin
              r_state <= ST_RUN;
            end else begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          r_acc <= w_dec;
          r_cnt <= r_cnt - W'(1);
          if (r_cnt == W'(1)) begin
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_state      <= ST_IDLE;
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_resp_valid <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dec_share_sched.sv
// Directed bench for dec_share_sched: reset, single/zero/multi-pass ops,
// backpressure, reset during an operation and round-robin ordering.
module tb_dec_share_sched;

  logic       clk;
  logic       rst;
  logic [3:0] req_valid;
  logic [7:0] req_data;
  logic [7:0] req_count;
  logic [3:0] req_ready;
  logic       resp_valid;
  logic       resp_ready;
  logic [1:0] resp_data;
  logic [1:0] resp_id;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;

  dec_share_sched #(.NREQ(4), .W(2), .IDW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_count  (req_count),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    req_count  = '0;
    resp_ready = 1'b0;
    tick();
    tick();

    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_busy",       32'(busy), 0);
    chk("rst_req_ready",  32'(req_ready), 0);
    chk("rst_resp_data",  32'(resp_data), 0);
    chk("rst_resp_id",    32'(resp_id), 0);

    rst = 1'b0;
    tick();

    // Single op: req0 data 00, count 1 -> 11
    req_data[1:0]  = 2'b00;
    req_count[1:0] = 2'd1;
    req_valid      = 4'b0001;
    #1;
    chk("single_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    chk("single_busy_run", 32'(busy), 1);
    chk("single_rv_run",   32'(resp_valid), 0);
    chk("single_rdy_run",  32'(req_ready), 0);
    tick();
    chk("single_rv",   32'(resp_valid), 1);
    chk("single_data", 32'(resp_data), 3);
    chk("single_id",   32'(resp_id), 0);
    chk("single_busy", 32'(busy), 1);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("single_done_rv",   32'(resp_valid), 0);
    chk("single_done_busy", 32'(busy), 0);

    // Zero count: req2 data 10 -> 10, ptr now 1
    req_data[5:4]  = 2'b10;
    req_count[5:4] = 2'd0;
    req_valid      = 4'b0100;
    #1;
    chk("zero_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    chk("zero_rv",   32'(resp_valid), 1);
    chk("zero_data", 32'(resp_data), 2);
    chk("zero_id",   32'(resp_id), 2);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Multi-pass wrap: req1 data 01 count 3 -> 10, ptr now 3
    req_data[3:2]  = 2'b01;
    req_count[3:2] = 2'd3;
    req_valid      = 4'b0010;
    #1;
    chk("multi_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    tick();
    chk("multi_rv_1", 32'(resp_valid), 0);
    tick();
    chk("multi_rv_2", 32'(resp_valid), 0);
    tick();
    chk("multi_rv",   32'(resp_valid), 1);
    chk("multi_data", 32'(resp_data), 2);
    chk("multi_id",   32'(resp_id), 1);

    // Backpressure with all others requesting
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_rv",    32'(resp_valid), 1);
      chk("bp_data",  32'(resp_data), 2);
      chk("bp_id",    32'(resp_id), 1);
      chk("bp_ready", 32'(req_ready), 0);
    end
    req_valid  = '0;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("bp_done_rv", 32'(resp_valid), 0);

    // Reset during RUN: req2 count 3, ptr is 2 so it would advance to 3
    req_data[5:4]  = 2'b01;
    req_count[5:4] = 2'd3;
    req_valid      = 4'b0100;
    #1;
    chk("rrun_ready", 32'(req_ready), 32'h4);
    tick();
    tick();
    chk("rrun_busy", 32'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rrun_rst_busy",  32'(busy), 0);
    chk("rrun_rst_rv",    32'(resp_valid), 0);
    chk("rrun_rst_ready", 32'(req_ready), 0);
    chk("rrun_rst_data",  32'(resp_data), 0);
    chk("rrun_rst_id",    32'(resp_id), 0);
    req_valid = '0;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("rrun_no_resp", 32'(resp_valid), 0);
    end

    // Round robin from ptr 0, all count 0, data[i] = 3 - i
    for (int i = 0; i < 4; i++) begin
      req_data[i*2 +: 2]  = 2'(3 - i);
      req_count[i*2 +: 2] = 2'd0;
    end
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      int exp_id;
      exp_id = k % 4;
      #1;
      chk("rr_grant", 32'(req_ready), 32'(1) << exp_id);
      tick();
      chk("rr_rv",   32'(resp_valid), 1);
      chk("rr_id",   32'(resp_id), 32'(exp_id));
      chk("rr_data", 32'(resp_data), 32'(3 - exp_id));
      chk("rr_bubble", 32'(req_ready), 0);
      tick();
    end
    req_valid  = '0;
    resp_ready = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
